// File: rtl/lin_sys3_cramer_seq_if.sv
// lin_sys3_cramer_seq_if: coefficient/result handshake bundle for the sequential 3x3 Cramer classifier
// Ports: in_valid/in_ready with row-major a1..d3 (W bits each) from the source;
// out_valid/out_ready with signed det_d/det_x/det_y/det_z (3*W+3 bits) and cls toward downstream.
// master = coefficient source / result sink, slave = the classifier.
interface lin_sys3_cramer_seq_if #(parameter int W = 3);
    localparam int DW = 3*W+3;
    logic in_valid, in_ready;
    logic [W-1:0] a1, b1, c1, d1, a2, b2, c2, d2, a3, b3, c3, d3;
    logic out_valid, out_ready;
    logic signed [DW-1:0] det_d, det_x, det_y, det_z;
    logic [1:0] cls;
    modport master (
        output in_valid, a1, b1, c1, d1, a2, b2, c2, d2, a3, b3, c3, d3, out_ready,
        input  in_ready, out_valid, det_d, det_x, det_y, det_z, cls
    );
    modport slave (
        input  in_valid, a1, b1, c1, d1, a2, b2, c2, d2, a3, b3, c3, d3, out_ready,
        output in_ready, out_valid, det_d, det_x, det_y, det_z, cls
    );
endinterface

// File: rtl/lin_sys3_cramer_seq.sv
// lin_sys3_cramer_seq: sequential 3x3 Cramer determinants (D, Dx, Dy, Dz) with unique/indeterminate/inconsistent class
// Ports: clk, rst (sync, active-high); bus (slave) carries the input handshake with coefficients
// and the held result handshake with the four determinants and cls.
module lin_sys3_cramer_seq #(
    parameter int W      = 3,
    parameter bit SIGNED = 1'b0
) (
    input logic clk,
    input logic rst,
    lin_sys3_cramer_seq_if.slave bus
);
    localparam int DW = 3*W+3;
    typedef logic signed [DW-1:0] val_t;
    typedef enum logic [1:0] {IDLE, CALC, CLASS, HOLD} state_t;
    state_t state, state_n;
    logic [1:0] j, t;
    val_t ca[3], cb[3], cc[3], cd[3];
    val_t acc[4];
    val_t col0[3], col1[3], col2[3];
    val_t m, p, q, r, s, term;

    function automatic val_t ext(input logic [W-1:0] x);
        return {{(DW-W){SIGNED && x[W-1]}}, x};
    endfunction

    // j picks which column is replaced by d; t picks the cofactor term of row 1
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            col0[i] = (j == 2'd1) ? cd[i] : ca[i];
            col1[i] = (j == 2'd2) ? cd[i] : cb[i];
            col2[i] = (j == 2'd3) ? cd[i] : cc[i];
        end
        m = (t == 2'd0) ? col0[0] : (t == 2'd1) ? col1[0] : col2[0];
        p = (t == 2'd0) ? col1[1] : col0[1];
        q = (t == 2'd2) ? col1[2] : col2[2];
        r = (t == 2'd2) ? col1[1] : col2[1];
        s = (t == 2'd0) ? col1[2] : col0[2];
        term = m * (p * q - r * s);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.in_valid ? CALC : IDLE;
            CALC:    state_n = (j == 2'd3 && t == 2'd2) ? CLASS : CALC;
            CLASS:   state_n = HOLD;
            default: state_n = bus.out_ready ? IDLE : HOLD;
        endcase
    end

    assign bus.in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            j <= 2'd0;
            t <= 2'd0;
            bus.out_valid <= 1'b0;
            bus.det_d <= '0;
            bus.det_x <= '0;
            bus.det_y <= '0;
            bus.det_z <= '0;
            bus.cls <= 2'b00;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (bus.in_valid) begin
                    ca[0] <= ext(bus.a1); cb[0] <= ext(bus.b1); cc[0] <= ext(bus.c1); cd[0] <= ext(bus.d1);
                    ca[1] <= ext(bus.a2); cb[1] <= ext(bus.b2); cc[1] <= ext(bus.c2); cd[1] <= ext(bus.d2);
                    ca[2] <= ext(bus.a3); cb[2] <= ext(bus.b3); cc[2] <= ext(bus.c3); cd[2] <= ext(bus.d3);
                    j <= 2'd0;
                    t <= 2'd0;
                end
                CALC: begin
                    // t=0 loads rather than adds; the middle cofactor term is subtracted
                    acc[j] <= ((t == 2'd0) ? '0 : acc[j]) + ((t == 2'd1) ? -term : term);
                    t <= (t == 2'd2) ? 2'd0 : t + 2'd1;
                    j <= (t == 2'd2) ? j + 2'd1 : j;
                end
                CLASS: begin
                    bus.det_d <= acc[0];
                    bus.det_x <= acc[1];
                    bus.det_y <= acc[2];
                    bus.det_z <= acc[3];
                    bus.cls <= (acc[0] != '0) ? 2'b01 : ((acc[1] | acc[2] | acc[3]) != '0) ? 2'b11 : 2'b10;
                    bus.out_valid <= 1'b1;
                end
                default: if (bus.out_ready) bus.out_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: doc/lin_sys3_cramer_seq.md
# lin_sys3_cramer_seq

Sequential, parametrised successor to the combinational 3x3 linear-system rank classifier. It accepts one 3x3 system A·x = d per valid/ready handshake and computes four determinants on shared arithmetic: D = det(A) and the Cramer numerators Dx, Dy, Dz. It then classifies the system as unique, indeterminate or inconsistent. It sits between the coefficient source and the downstream solver/divider stage, and presents a held result with back-pressure.

## Interface
- W, default 3: coefficient width in bits.
- SIGNED, default 0: 0 means coefficients are unsigned; 1 means two's complement.
- DW (localparam) = 3*W+3: signed width of every determinant output. No overflow is possible for either SIGNED mode.
- clk  in  1  clock. Every register is updated on its rising edge.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  coefficient set is valid.
- in_ready  out  1  block can accept a coefficient set.
- a1,b1,c1,d1,a2,b2,c2,d2,a3,b3,c3,d3  in  W each  row-major coefficients. Row i is ai·x + bi·y + ci·z = di.
- out_valid  out  1  result valid. It is held until out_ready.
- out_ready  in  1  downstream accepts the result.
- det_d, det_x, det_y, det_z  out  DW each, signed  D, Dx, Dy, Dz.
- cls  out  2  classification:
  - 01: unique solution.
  - 10: indeterminate (infinite solutions or degenerate).
  - 11: inconsistent.
  - 00: never emitted after a computation.

## Operation
- States: IDLE, CALC, CLASS, HOLD.
- IDLE:
  - in_ready=1.
  - When in_valid is high, all 12 inputs are captured into internal registers, sign- or zero-extended per SIGNED.
  - Next state is CALC with phase counter k=0.
  - Inputs are ignored after capture.
- CALC: takes 12 cycles, k=0..11.
  - Determinant index j=k/3 selects the matrix:
    - j=0: A.
    - j=1: A with column a replaced by d.
    - j=2: A with column b replaced by d.
    - j=3: A with column c replaced by d.
  - Term t=k%3 is one cofactor term. Each cycle adds sign_t·m_t·(p·q − r·s) into the accumulator for index j.
    - t=0: +a1·(b2c3−c2b3).
    - t=1: −b1·(a2c3−c2a3).
    - t=2: +c1·(a2b3−b2a3).
    - The substituted matrix supplies the entries.
  - The accumulator for index j clears at t=0 (load, not add).
  - Arithmetic is full-precision signed at DW bits. Intermediate values are never truncated below DW.
- CLASS: takes 1 cycle.
  - The result registers load D, Dx, Dy, Dz and cls.
  - cls=01 if D≠0.
  - cls=11 if D=0 and any of Dx, Dy, Dz ≠ 0.
  - cls=10 if all four are 0.
  - out_valid is set to 1 and the state moves to HOLD.
- HOLD:
  - Outputs are stable and in_ready=0.
  - When out_valid and out_ready are both high, out_valid clears and the state returns to IDLE.
  - Result registers keep their last values after the handshake.
- in_ready is 1 only in IDLE with rst low. There is no overlap between a new accept and a pending result.
- in_valid in any state other than IDLE is ignored. The source must hold it until in_ready.

## Timing
- Reset values: out_valid=0, det_d=det_x=det_y=det_z=0, cls=00, state=IDLE, k=0. in_ready=0 while rst is high.
- Accept on edge T:
  - CALC occupies edges T+1..T+12.
  - CLASS occurs at edge T+13.
  - out_valid is high from after edge T+13.
- Latency from accept to out_valid is 13 cycles.
- If out_ready is already high, the handshake completes at edge T+14. in_ready=1 after edge T+14. The next accept is possible at edge T+15.
- Throughput is at most one system per 15 cycles.
- Back-pressure: out_ready low holds HOLD indefinitely, with outputs bit-stable.
- rst high on any edge aborts the in-flight computation, returns the block to IDLE and applies the reset values. There is no partial result and no spurious out_valid.
- rst and in_valid high on the same edge: reset wins and nothing is captured.

## Test plan
- W=3, SIGNED=0.
  - Stimulus: A=[3 0 3; 0 3 3; 3 3 0], d=(0,0,1).
  - Required: D=−54, Dx=−9, Dy=−9, Dz=9, cls=01. out_valid rises exactly 13 cycles after accept.
- Same A, row 3 all zero, d3=1:
  - Required: D=0, Dx=−9, cls=11.
  - Variant with d3=0: D=Dx=Dy=Dz=0, cls=10.
- Identity matrix, d=(1,2,3):
  - Required: D=1, Dx=1, Dy=2, Dz=3, cls=01.
  - All-7 matrix and all-7 d: all four determinants 0, cls=10.
- W=4, SIGNED=1.
  - Stimulus: A=diag(−1,2,3), d=(1,1,1).
  - Required: D=−6, Dx=6, Dy=−3, Dz=−2, cls=01.
  - Also check all entries at most-negative (−8): D=0, no overflow.
- Back-pressure and handshake:
  - Hold out_ready=0 for 20 cycles: outputs stable, in_ready=0, a second in_valid is ignored.
  - Release out_ready: handshake completes and in_ready rises the next cycle.
  - Back-to-back systems with out_ready=1 are accepted every 15 cycles.
- Reset:
  - Assert rst at CALC k=5: all outputs return to reset values on that edge. No out_valid follows.
  - A fresh system after reset produces the correct result.
